// File: rtl/note_hit_judge.sv
// note_hit_judge: per-lane note judgment (perfect/good/miss/ghost)
// plus score, streak and multiplier bookkeeping for the HUD.
module note_hit_judge #(
  parameter logic [9:0]  HIT_Y_MIN   = 10'd380,
  parameter logic [9:0]  HIT_Y_MAX   = 10'd440,
  parameter logic [9:0]  PERF_Y_MIN  = 10'd400,
  parameter logic [9:0]  PERF_Y_MAX  = 10'd420,
  parameter logic [15:0] PTS_PERFECT = 16'd100,
  parameter logic [15:0] PTS_GOOD    = 16'd50
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [9:0]  note_y_pos,
  input  logic        note_active,
  input  logic        key_pressed,
  output logic        hit_pulse,
  output logic        perfect_pulse,
  output logic        miss_pulse,
  output logic        ghost_pulse,
  output logic [15:0] score,
  output logic [7:0]  streak,
  output logic [2:0]  multiplier
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRACK,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic       r_key_s;
  logic       r_frame_s;
  logic       r_act_s;
  logic [9:0] r_y_s;

  logic       r_key_d;
  logic       r_frame_d;
  logic       r_key_edge;
  logic       r_frame_edge;
  logic       r_act_q;
  logic [9:0] r_y_q;

  logic        r_hit;
  logic        r_perf;
  logic        r_miss;
  logic        r_ghost;
  logic [15:0] r_score;
  logic [7:0]  r_streak;
  logic [2:0]  r_mult;

  logic        w_hit;
  logic        w_perf_hit;
  logic        w_miss;
  logic        w_ghost;
  logic        w_clear;
  logic        w_in_win;
  logic        w_early;
  logic        w_late;
  logic        w_perf_win;
  logic [15:0] w_base;
  logic [15:0] w_points;
  logic [16:0] w_sum;
  logic [15:0] w_score_nx;
  logic [7:0]  w_streak_inc;

  // Multiplier tier from a streak: 1 + streak/10, capped at 4.
  function automatic logic [2:0] f_mult(input logic [7:0] s);
    if (s >= 8'd30)      return 3'd4;
    else if (s >= 8'd20) return 3'd3;
    else if (s >= 8'd10) return 3'd2;
    else                 return 3'd1;
  endfunction

  // Sample inputs, then build edges; y and active travel alongside
  // so the judge sees a consistent snapshot with each edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_key_s      <= 1'b0;
      r_frame_s    <= 1'b0;
      r_act_s      <= 1'b0;
      r_y_s        <= '0;
      r_key_d      <= 1'b0;
      r_frame_d    <= 1'b0;
      r_key_edge   <= 1'b0;
      r_frame_edge <= 1'b0;
      r_act_q      <= 1'b0;
      r_y_q        <= '0;
    end else begin
      r_key_s      <= key_pressed;
      r_frame_s    <= frame_clk;
      r_act_s      <= note_active;
      r_y_s        <= note_y_pos;
      r_key_d      <= r_key_s;
      r_frame_d    <= r_frame_s;
      r_key_edge   <= r_key_s & ~r_key_d;
      r_frame_edge <= r_frame_s & ~r_frame_d;
      r_act_q      <= r_act_s;
      r_y_q        <= r_y_s;
    end
  end

  assign w_in_win   = (r_y_q >= HIT_Y_MIN) && (r_y_q <= HIT_Y_MAX);
  assign w_early    = (r_y_q < HIT_Y_MIN);
  assign w_late     = (r_y_q > HIT_Y_MAX);
  assign w_perf_win = (r_y_q >= PERF_Y_MIN) && (r_y_q <= PERF_Y_MAX);

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Judgment: key is evaluated before the frame-tick miss rule.
  always_comb begin
    w_state_nx = r_state;
    w_hit      = 1'b0;
    w_perf_hit = 1'b0;
    w_miss     = 1'b0;
    w_ghost    = 1'b0;
    w_clear    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_key_edge) w_ghost = 1'b1;
        if (r_act_q)    w_state_nx = S_TRACK;
      end
      S_TRACK: begin
        if (r_key_edge && w_in_win) begin
          w_hit      = 1'b1;
          w_perf_hit = w_perf_win;
          w_state_nx = S_DONE;
        end else if (r_key_edge && w_early) begin
          w_ghost = 1'b1;
          w_clear = 1'b1;
        end else if (r_frame_edge && w_late) begin
          w_miss     = 1'b1;
          w_clear    = 1'b1;
          w_state_nx = S_DONE;
        end else if (r_key_edge) begin
          // late press before the miss tick: no note to match
          w_ghost = 1'b1;
        end else if (!r_act_q) begin
          w_miss     = 1'b1;
          w_clear    = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      S_DONE: begin
        if (r_key_edge) w_ghost = 1'b1;
        if (!r_act_q)   w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign w_base       = w_perf_hit ? PTS_PERFECT : PTS_GOOD;
  assign w_points     = w_base * {13'd0, r_mult};
  assign w_sum        = {1'b0, r_score} + {1'b0, w_points};
  assign w_score_nx   = w_sum[16] ? 16'hFFFF : w_sum[15:0];
  assign w_streak_inc = (r_streak == 8'hFF) ? 8'hFF : r_streak + 8'd1;

  // Register pulses and scoreboard updates together.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_hit    <= 1'b0;
      r_perf   <= 1'b0;
      r_miss   <= 1'b0;
      r_ghost  <= 1'b0;
      r_score  <= '0;
      r_streak <= '0;
      r_mult   <= 3'd1;
    end else begin
      r_hit   <= w_hit;
      r_perf  <= w_perf_hit;
      r_miss  <= w_miss;
      r_ghost <= w_ghost;
      if (w_hit) begin
        r_score  <= w_score_nx;
        r_streak <= w_streak_inc;
        r_mult   <= f_mult(w_streak_inc);
      end else if (w_clear) begin
        r_streak <= '0;
        r_mult   <= 3'd1;
      end
    end
  end

  assign hit_pulse     = r_hit;
  assign perfect_pulse = r_perf;
  assign miss_pulse    = r_miss;
  assign ghost_pulse   = r_ghost;
  assign score         = r_score;
  assign streak        = r_streak;
  assign multiplier    = r_mult;

endmodule

// File: tb/tb_note_hit_judge.sv
// tb_note_hit_judge: table vectors, directed sequences and random
// events checked against a note-level scoring model.
module tb_note_hit_judge;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic [9:0]  note_y_pos = '0;
  logic        note_active = 1'b0;
  logic        key_pressed = 1'b0;
  logic        hit_pulse;
  logic        perfect_pulse;
  logic        miss_pulse;
  logic        ghost_pulse;
  logic [15:0] score;
  logic [7:0]  streak;
  logic [2:0]  multiplier;

  note_hit_judge dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_clk     (frame_clk),
    .note_y_pos    (note_y_pos),
    .note_active   (note_active),
    .key_pressed   (key_pressed),
    .hit_pulse     (hit_pulse),
    .perfect_pulse (perfect_pulse),
    .miss_pulse    (miss_pulse),
    .ghost_pulse   (ghost_pulse),
    .score         (score),
    .streak        (streak),
    .multiplier    (multiplier)
  );

  always #10 Clk = ~Clk;

  typedef struct {
    logic       key;
    logic       frm;
    logic       act;
    logic [9:0] y;
    logic [3:0] pul;
    int         sc;
    int         st;
    int         mu;
  } vec_t;

  vec_t tbl [30];
  int   n_vec = 0;
  int   n_bad = 0;

  // note-level model: phase 0 = no note, 1 = judgeable, 2 = judged
  int   m_score = 0;
  int   m_streak = 0;
  int   m_phase = 0;
  logic cur_act = 1'b0;

  function automatic int mmult(input int s);
    int m;
    m = 1 + s / 10;
    return (m > 4) ? 4 : m;
  endfunction

  // Expected pulses are {hit, perfect, miss, ghost}.
  task automatic model_step(input logic k, input logic f,
                            input logic a, input int y,
                            output logic [3:0] ep);
    int pts;
    ep = 4'b0000;
    if (m_phase == 0) begin
      if (k) ep[0] = 1'b1;
      if (a) m_phase = 1;
    end else if (m_phase == 1) begin
      if (k && y >= 380 && y <= 440) begin
        ep[3] = 1'b1;
        ep[2] = (y >= 400 && y <= 420);
        pts = (ep[2] ? 100 : 50) * mmult(m_streak);
        m_score = (m_score + pts > 65535) ? 65535 : m_score + pts;
        m_streak = (m_streak >= 255) ? 255 : m_streak + 1;
        m_phase = 2;
      end else if (k && y < 380) begin
        ep[0] = 1'b1;
        m_streak = 0;
      end else if (f && y > 440) begin
        ep[1] = 1'b1;
        m_streak = 0;
        m_phase = 2;
      end else if (k) begin
        ep[0] = 1'b1;
      end else if (!a) begin
        ep[1] = 1'b1;
        m_streak = 0;
        m_phase = 0;
      end
    end else begin
      if (k) ep[0] = 1'b1;
      if (!a) m_phase = 0;
    end
  endtask

  task automatic ev(input logic k, input logic f, input logic a,
                    input logic [9:0] y, input bit use_tbl,
                    input logic [3:0] tp, input int tsc,
                    input int tst, input int tmu, input string nm);
    logic [3:0] got [5];
    logic [3:0] ep;
    int esc, est, emu;
    bit bad;
    model_step(k, f, a, int'(y), ep);
    if (use_tbl) begin
      ep  = tp;
      esc = tsc;
      est = tst;
      emu = tmu;
    end else begin
      esc = m_score;
      est = m_streak;
      emu = mmult(m_streak);
    end
    @(negedge Clk);
    key_pressed = k;
    frame_clk   = f;
    note_active = a;
    note_y_pos  = y;
    cur_act     = a;
    for (int c = 0; c < 5; c++) begin
      @(posedge Clk);
      #1;
      got[c] = {hit_pulse, perfect_pulse, miss_pulse, ghost_pulse};
    end
    bad = 1'b0;
    for (int c = 0; c < 5; c++)
      if (got[c] !== ((c == 2) ? ep : 4'b0000)) bad = 1'b1;
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("FAIL %s pulses: got %b %b %b %b %b, required %b at 3rd clk",
               nm, got[0], got[1], got[2], got[3], got[4], ep);
    end
    n_vec++;
    if (int'(score) != esc || int'(streak) != est ||
        int'(multiplier) != emu) begin
      n_bad++;
      $display("FAIL %s totals: got %0d/%0d/x%0d, required %0d/%0d/x%0d",
               nm, score, streak, multiplier, esc, est, emu);
    end
    @(negedge Clk);
    key_pressed = 1'b0;
    frame_clk   = 1'b0;
    repeat (3) @(posedge Clk);
  endtask

  task automatic mev(input logic k, input logic f, input logic a,
                     input logic [9:0] y, input string nm);
    ev(k, f, a, y, 1'b0, 4'b0000, 0, 0, 0, nm);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset       = 1'b1;
    note_active = 1'b0;
    key_pressed = 1'b0;
    frame_clk   = 1'b0;
    cur_act     = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    n_vec++;
    if (score !== 16'd0 || streak !== 8'd0 || multiplier !== 3'd1 ||
        {hit_pulse, perfect_pulse, miss_pulse, ghost_pulse} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset: got %0d/%0d/x%0d pulses %b, required 0/0/x1 0000",
               score, streak, multiplier,
               {hit_pulse, perfect_pulse, miss_pulse, ghost_pulse});
    end
    @(negedge Clk);
    Reset = 1'b0;
    m_score  = 0;
    m_streak = 0;
    m_phase  = 0;
    repeat (3) @(posedge Clk);
  endtask

  task automatic hit_perfect();
    mev(1'b0, 1'b0, 1'b1, 10'd410, "hp_act");
    mev(1'b1, 1'b0, 1'b1, 10'd410, "hp_key");
    mev(1'b0, 1'b0, 1'b0, 10'd0, "hp_off");
  endtask

  initial begin
    bit bad;
    logic [9:0] ry;
    int kind;

    tbl[0]  = '{0, 0, 1, 10'd410, 4'b0000,   0, 0, 1};
    tbl[1]  = '{1, 0, 1, 10'd410, 4'b1100, 100, 1, 1};
    tbl[2]  = '{0, 0, 0, 10'd0,   4'b0000, 100, 1, 1};
    tbl[3]  = '{0, 0, 1, 10'd380, 4'b0000, 100, 1, 1};
    tbl[4]  = '{1, 0, 1, 10'd380, 4'b1000, 150, 2, 1};
    tbl[5]  = '{0, 0, 0, 10'd0,   4'b0000, 150, 2, 1};
    tbl[6]  = '{0, 0, 1, 10'd200, 4'b0000, 150, 2, 1};
    tbl[7]  = '{1, 0, 1, 10'd200, 4'b0001, 150, 0, 1};
    tbl[8]  = '{1, 0, 1, 10'd379, 4'b0001, 150, 0, 1};
    tbl[9]  = '{1, 0, 1, 10'd420, 4'b1100, 250, 1, 1};
    tbl[10] = '{1, 0, 1, 10'd420, 4'b0001, 250, 1, 1};
    tbl[11] = '{0, 0, 0, 10'd0,   4'b0000, 250, 1, 1};
    tbl[12] = '{0, 0, 1, 10'd399, 4'b0000, 250, 1, 1};
    tbl[13] = '{0, 1, 1, 10'd440, 4'b0000, 250, 1, 1};
    tbl[14] = '{1, 0, 1, 10'd399, 4'b1000, 300, 2, 1};
    tbl[15] = '{0, 0, 0, 10'd0,   4'b0000, 300, 2, 1};
    tbl[16] = '{0, 0, 1, 10'd441, 4'b0000, 300, 2, 1};
    tbl[17] = '{0, 1, 1, 10'd441, 4'b0010, 300, 0, 1};
    tbl[18] = '{0, 0, 0, 10'd0,   4'b0000, 300, 0, 1};
    tbl[19] = '{0, 0, 1, 10'd441, 4'b0000, 300, 0, 1};
    tbl[20] = '{1, 0, 1, 10'd441, 4'b0001, 300, 0, 1};
    tbl[21] = '{0, 0, 0, 10'd441, 4'b0010, 300, 0, 1};
    tbl[22] = '{1, 0, 0, 10'd100, 4'b0001, 300, 0, 1};
    tbl[23] = '{0, 0, 1, 10'd440, 4'b0000, 300, 0, 1};
    tbl[24] = '{1, 1, 1, 10'd440, 4'b1000, 350, 1, 1};
    tbl[25] = '{1, 0, 1, 10'd440, 4'b0001, 350, 1, 1};
    tbl[26] = '{0, 0, 0, 10'd0,   4'b0000, 350, 1, 1};
    tbl[27] = '{0, 0, 1, 10'd441, 4'b0000, 350, 1, 1};
    tbl[28] = '{1, 1, 1, 10'd441, 4'b0010, 350, 0, 1};
    tbl[29] = '{0, 0, 0, 10'd0,   4'b0000, 350, 0, 1};

    // idle after reset: quiet outputs for 100 clocks
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge Clk);
      #1;
      if (score !== 16'd0 || streak !== 8'd0 || multiplier !== 3'd1 ||
          {hit_pulse, perfect_pulse, miss_pulse, ghost_pulse} !== 4'b0)
        bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("FAIL idle: got %0d/%0d/x%0d or pulses, required 0/0/x1 quiet",
               score, streak, multiplier);
    end

    for (int i = 0; i < 30; i++)
      ev(tbl[i].key, tbl[i].frm, tbl[i].act, tbl[i].y, 1'b1,
         tbl[i].pul, tbl[i].sc, tbl[i].st, tbl[i].mu,
         $sformatf("tbl%0d", i));

    // multiplier tiers and saturation
    do_reset();
    for (int i = 0; i < 10; i++) hit_perfect();
    chk("ten_score", int'(score), 1000);
    chk("ten_streak", int'(streak), 10);
    chk("ten_mult", int'(multiplier), 2);
    hit_perfect();
    chk("eleven_score", int'(score), 1200);
    for (int i = 11; i < 178; i++) hit_perfect();
    chk("pre_sat_score", int'(score), 65200);
    hit_perfect();
    chk("sat_score", int'(score), 65535);
    chk("sat_streak179", int'(streak), 179);
    for (int i = 179; i < 260; i++) hit_perfect();
    chk("streak_sat", int'(streak), 255);
    chk("mult_max", int'(multiplier), 4);
    chk("score_held", int'(score), 65535);

    // reset in the middle of a tracked note
    mev(1'b0, 1'b0, 1'b1, 10'd410, "mid_act");
    do_reset();
    ev(1'b1, 1'b0, 1'b0, 10'd410, 1'b1, 4'b0001, 0, 0, 1, "post_rst_ghost");

    // random events against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      kind = int'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) ry = 10'($urandom_range(0, 1023));
      else                           ry = 10'($urandom_range(370, 450));
      if (kind < 2)      mev(1'b0, 1'b0, ~cur_act, ry, "rnd_act");
      else if (kind < 6) mev(1'b1, 1'b0, cur_act, ry, "rnd_key");
      else if (kind < 8) mev(1'b0, 1'b1, cur_act, ry, "rnd_frame");
      else if (kind < 9) mev(1'b1, 1'b1, cur_act, ry, "rnd_both");
      else               mev(1'b0, 1'b0, cur_act, ry, "rnd_y");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/note_hit_judge.md
Name: note_hit_judge

Overview:
- Consumer end of one lane's falling-note interface. Reads the note's Y position and an active flag from the lane sprite, together with the player's fret key for that lane.
- Judges each note as exactly one of: perfect hit, good hit, or miss. Key presses that match no note are flagged as ghost presses.
- Maintains the lane's score, streak and multiplier for the scoreboard and HUD.
- One instance per lane; sits between the sprite blocks, the keycode decoder and the score display.

Parameters:
- HIT_Y_MIN, 10'd380, lowest note_y_pos (inclusive) accepted as a hit.
- HIT_Y_MAX, 10'd440, highest note_y_pos (inclusive) accepted as a hit.
- PERF_Y_MIN, 10'd400, lower bound (inclusive) of the perfect sub-window.
- PERF_Y_MAX, 10'd420, upper bound (inclusive) of the perfect sub-window.
- PTS_PERFECT, 16'd100, base points for a perfect hit.
- PTS_GOOD, 16'd50, base points for a good hit.

Ports:
- Clk, input, 1, 50 MHz system clock.
- Reset, input, 1, synchronous active-high reset.
- frame_clk, input, 1, frame tick (~60 Hz), asynchronous in phase to note updates but sampled on Clk.
- note_y_pos, input, 10, top edge Y of the lane note.
- note_active, input, 1, high while the note is falling (its motion equals its step).
- key_pressed, input, 1, level from the keycode decoder; already debounced.
- hit_pulse, output, 1, one-Clk pulse on a good or perfect hit.
- perfect_pulse, output, 1, one-Clk pulse on a perfect hit; asserted together with hit_pulse.
- miss_pulse, output, 1, one-Clk pulse when the note leaves the window unhit.
- ghost_pulse, output, 1, one-Clk pulse on a key press that matched no note.
- score, output, 16, accumulated score; saturates.
- streak, output, 8, consecutive hits; saturates.
- multiplier, output, 3, current multiplier, range 1..4.

Behaviour:
- Reset (synchronous, active-high; wins over all other events):
  - score=0, streak=0, multiplier=1; all pulse outputs 0.
  - State goes to IDLE; the edge-detect registers are cleared.
  - Reset asserted mid-note discards any judgment in flight.
- Edge detection:
  - key_edge = key_pressed & ~key_d, registered once.
  - frame_edge = frame_clk & ~frame_d, registered once.
  - Each edge is therefore seen one Clk after its input rises.
- Latency:
  - All pulses and score/streak/multiplier updates are registered together.
  - They appear 2 Clk after the triggering input is first sampled high.
- State machine:
  - IDLE:
    - note_active=1 → TRACK.
    - key_edge → ghost_pulse.
  - TRACK:
    - key_edge with HIT_Y_MIN ≤ note_y_pos ≤ HIT_Y_MAX → hit; go to DONE.
    - key_edge with note_y_pos < HIT_Y_MIN → ghost_pulse, streak cleared, remain in TRACK (the note stays judgeable).
    - frame_edge with note_y_pos > HIT_Y_MAX → miss_pulse, streak cleared; go to DONE.
    - note_active falls while in TRACK → treated as a miss; go to IDLE.
  - DONE:
    - key_edge → ghost_pulse; streak is not cleared.
    - note_active=0 → IDLE.
- Simultaneous events:
  - key_edge and frame_edge in the same cycle: key is evaluated first. In-window key → hit, and frame_edge is ignored. Otherwise the miss rule applies.
  - Only one judgment per note, ever.
- Hit arithmetic:
  - Perfect when PERF_Y_MIN ≤ note_y_pos ≤ PERF_Y_MAX; otherwise good.
  - Points = base × multiplier, where the multiplier is the value before this hit.
  - score = min(score + points, 16'hFFFF); the sum is computed at 17 bits.
  - streak = min(streak + 1, 255).
- Multiplier:
  - multiplier = min(4, 1 + streak/10), recomputed from the updated streak in the same cycle as the streak update.
- Any streak clear (miss or early ghost) forces multiplier=1 in the same cycle.
- Window bounds are inclusive on both ends; note_y_pos wrapping to 0 on note retire is not a judgment event.

Test Plan:
- Reset → IDLE; score=0, streak=0, multiplier=1; no pulses for 100 Clk.
- note_active=1, note_y_pos=410, key rises → hit_pulse and perfect_pulse 2 Clk later; score=100, streak=1.
- note_y_pos=380 (inclusive edge), key rises → hit_pulse only; score +50; at 441 with a frame_edge → miss_pulse, streak=0, multiplier=1.
- Ten perfect hits from reset → streak=10, multiplier=2, score=1000; the eleventh perfect hit → score=1200.
- Same-cycle key_edge and frame_edge at note_y_pos=440 → hit, no miss; key rising again in DONE → ghost_pulse, streak unchanged.
- Preload score to 65500 and score a perfect hit → score=65535; Reset mid-TRACK → outputs zero, and the next key press gives ghost_pulse from IDLE.
